// File: rtl/pc_next_gen_if.sv
// Fetch-PC bus: next-PC selection and targets in, fetch PC and status out.
interface pc_next_gen_if;
  logic [2:0]  PCSel;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] epc;
  logic [31:0] mem_pc;
  logic        if_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_adel;
  logic        redirect_pulse;

  modport master (
    output PCSel, jump_target, branch_target, jr_target, epc, mem_pc, if_ready,
    input  pc, pc_valid, pc_adel, redirect_pulse
  );

  modport slave (
    input  PCSel, jump_target, branch_target, jr_target, epc, mem_pc, if_ready,
    output pc, pc_valid, pc_adel, redirect_pulse
  );
endinterface

// File: rtl/pc_next_gen.sv
// Architectural fetch PC with a one-entry pending redirect buffer.
// Redirects seen while IF is stalled are held until the next accept.
module pc_next_gen #(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380
) (
  input logic         clk,
  input logic         resetn,
  pc_next_gen_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;

  state_t      state, stateNxt;
  logic [31:0] pcQ, pcNxt, pendTgt, pendNxt, selTgt;
  logic        validQ, adelQ, pulseQ, loadRedir;
  logic        isExc, isCtrl, accept;

  assign isExc  = (bus.PCSel == 3'b010) || (bus.PCSel == 3'b011) || (bus.PCSel == 3'b110);
  assign isCtrl = (bus.PCSel == 3'b001) || (bus.PCSel == 3'b100) || (bus.PCSel == 3'b101);
  assign accept = validQ && bus.if_ready;

  always_comb begin
    selTgt = pcQ + 32'd4;
    case (bus.PCSel)
      3'b001:  selTgt = bus.jump_target;
      3'b010:  selTgt = bus.epc;
      3'b011:  selTgt = EXC_VEC;
      3'b100:  selTgt = bus.branch_target;
      3'b101:  selTgt = bus.jr_target;
      3'b110:  selTgt = bus.mem_pc;
      default: selTgt = pcQ + 32'd4;
    endcase
  end

  always_comb begin
    stateNxt  = state;
    pcNxt     = pcQ;
    pendNxt   = pendTgt;
    loadRedir = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pcNxt     = selTgt;
          loadRedir = isExc || isCtrl;
        end else if (isExc || isCtrl) begin
          pendNxt  = selTgt;
          stateNxt = PEND;
        end
      end
      PEND: begin
        // A fresh exception outranks whatever is pending; older control transfers win over newer ones.
        if (accept) begin
          pcNxt     = isExc ? selTgt : pendTgt;
          loadRedir = 1'b1;
          stateNxt  = IDLE;
        end else if (isExc) begin
          pendNxt = selTgt;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      pcQ     <= RESET_VEC;
      pendTgt <= '0;
      validQ  <= 1'b0;
      adelQ   <= 1'b0;
      pulseQ  <= 1'b0;
    end else begin
      state   <= stateNxt;
      pcQ     <= pcNxt;
      pendTgt <= pendNxt;
      validQ  <= 1'b1;
      adelQ   <= (pcNxt[1:0] != 2'b00);
      pulseQ  <= loadRedir;
    end
  end

  assign bus.pc             = pcQ;
  assign bus.pc_valid       = validQ;
  assign bus.pc_adel        = adelQ;
  assign bus.redirect_pulse = pulseQ;
endmodule

// File: tb/tb_pc_next_gen.sv
// Bench for pc_next_gen: directed scenarios plus random traffic against a behavioural model.
module tb_pc_next_gen;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pc_next_gen_if bus();
  pc_next_gen #(.RESET_VEC(RV), .EXC_VEC(EV)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int errs = 0;
  int checks = 0;

  // Model state: architectural PC, flags, and a queue holding at most one pending target.
  logic [31:0] mPc = RV;
  bit mValid = 0, mAdel = 0, mPulse = 0;
  logic [31:0] pendQ[$];

  // 0 = sequential, 1 = control transfer, 2 = exception class
  function automatic int cls(input logic [2:0] s);
    case (s)
      3'b001, 3'b100, 3'b101: return 1;
      3'b010, 3'b011, 3'b110: return 2;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [31:0] tgt(input logic [2:0] s);
    case (s)
      3'b001:  return bus.jump_target;
      3'b010:  return bus.epc;
      3'b011:  return EV;
      3'b100:  return bus.branch_target;
      3'b101:  return bus.jr_target;
      3'b110:  return bus.mem_pc;
      default: return mPc + 32'd4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic [2:0] sel, input logic rdy);
    bus.PCSel = sel;
    bus.if_ready = rdy;
  endtask

  // Advance one clock: predict from current inputs, then compare every output.
  task automatic cyc();
    int c;
    logic [31:0] t, nPc;
    bit acc, nValid, nAdel, nPulse;
    c = cls(bus.PCSel);
    t = tgt(bus.PCSel);
    acc = mValid && bus.if_ready;
    nPc = mPc; nValid = 1; nPulse = 0;
    if (!resetn) begin
      nPc = RV; nValid = 0; pendQ.delete();
    end else if (acc) begin
      if (pendQ.size() != 0) begin
        nPc = (c == 2) ? t : pendQ[0];
        nPulse = 1;
        pendQ.delete();
      end else begin
        nPc = t;
        nPulse = (c != 0);
      end
    end else if (c != 0) begin
      if (pendQ.size() == 0) pendQ.push_back(t);
      else if (c == 2) pendQ[0] = t;
    end
    nAdel = resetn && (nPc % 4 != 0);
    @(posedge clk);
    #1;
    mPc = nPc; mValid = nValid; mAdel = nAdel; mPulse = nPulse;
    chk("pc", bus.pc, mPc);
    chk("pc_valid", {31'b0, bus.pc_valid}, {31'b0, mValid});
    chk("pc_adel", {31'b0, bus.pc_adel}, {31'b0, mAdel});
    chk("redirect_pulse", {31'b0, bus.redirect_pulse}, {31'b0, mPulse});
  endtask

  initial begin
    bus.jump_target = 32'h8000_0400;
    bus.branch_target = 32'h8000_1000;
    bus.jr_target = 32'h8000_2000;
    bus.epc = 32'h8000_0100;
    bus.mem_pc = 32'h8000_5000;
    setIn(3'b000, 1'b1);

    // Reset then sequential fetch
    resetn = 0; cyc();
    chk("t1 reset pc", bus.pc, RV);
    chk("t1 reset valid", {31'b0, bus.pc_valid}, 32'd0);
    resetn = 1; cyc();
    chk("t1 first valid", {31'b0, bus.pc_valid}, 32'd1);
    cyc(); cyc(); cyc();
    chk("t1 pc seq", bus.pc, 32'hBFC0_000C);
    chk("t1 model seq", mPc, 32'hBFC0_000C);
    cyc();

    // Branch taken on accept
    setIn(3'b100, 1'b1); cyc();
    chk("t2 branch pc", bus.pc, 32'h8000_1000);
    chk("t2 pulse", {31'b0, bus.redirect_pulse}, 32'd1);
    setIn(3'b000, 1'b1); cyc();
    chk("t2 pulse drop", {31'b0, bus.redirect_pulse}, 32'd0);

    // JR while stalled, held through stall
    setIn(3'b101, 1'b0); cyc();
    setIn(3'b000, 1'b0); cyc(); cyc(); cyc();
    chk("t3 hold pc", bus.pc, 32'h8000_1004);
    setIn(3'b000, 1'b1); cyc();
    chk("t3 jr pc", bus.pc, 32'h8000_2000);

    // Pending CTRL overwritten by exception
    setIn(3'b101, 1'b0); cyc();
    setIn(3'b011, 1'b0); cyc();
    setIn(3'b000, 1'b1); cyc();
    chk("t4 exc pc", bus.pc, EV);

    // Pending EXC not displaced by later branch
    bus.branch_target = 32'h8000_3000;
    setIn(3'b010, 1'b0); cyc();
    setIn(3'b100, 1'b0); cyc();
    setIn(3'b000, 1'b1); cyc();
    chk("t5 epc pc", bus.pc, 32'h8000_0100);

    // Exception arriving on the accepting cycle replaces pending
    bus.branch_target = 32'h8000_4000;
    setIn(3'b100, 1'b0); cyc();
    setIn(3'b110, 1'b1); cyc();
    chk("t5b mempc", bus.pc, 32'h8000_5000);

    // Misaligned JR, then reset while pending
    bus.jr_target = 32'h8000_0002;
    setIn(3'b101, 1'b1); cyc();
    chk("t6 adel pc", bus.pc, 32'h8000_0002);
    chk("t6 adel", {31'b0, bus.pc_adel}, 32'd1);
    setIn(3'b001, 1'b0); cyc();
    resetn = 0; cyc();
    chk("t6 reset pc", bus.pc, RV);
    resetn = 1; setIn(3'b000, 1'b1); cyc(); cyc();
    chk("t6 pend cleared", bus.pc, RV + 32'd4);

    // 32-bit wrap and illegal code
    bus.jr_target = 32'hFFFF_FFFC;
    setIn(3'b101, 1'b1); cyc();
    setIn(3'b000, 1'b1); cyc();
    chk("wrap pc", bus.pc, 32'h0000_0000);
    setIn(3'b111, 1'b1); cyc();
    chk("illegal pc", bus.pc, 32'h0000_0004);
    chk("illegal pulse", {31'b0, bus.redirect_pulse}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 63) != 0);
      bus.jump_target = $urandom();
      bus.branch_target = $urandom() & 32'hFFFF_FFFC;
      bus.jr_target = $urandom();
      bus.epc = $urandom() & 32'hFFFF_FFFC;
      bus.mem_pc = $urandom() & 32'hFFFF_FFFC;
      setIn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
